// File: rtl/halt_controller_pkg.sv
// Shared definitions for the halt controller: state encodings, halt-cause codes, opcodes.
// Optional single-step support is enabled with the HALT_STEP_EN macro.
package halt_controller_pkg;

  typedef enum logic [1:0] {
    HALT_ST_RUN    = 2'b00,
    HALT_ST_DRAIN  = 2'b01,
    HALT_ST_HALTED = 2'b10,
    HALT_ST_RESUME = 2'b11
  } halt_state_e;

  typedef enum logic [1:0] {
    HALT_CAUSE_NONE     = 2'b00,
    HALT_CAUSE_EBREAK   = 2'b01,
    HALT_CAUSE_EXTERNAL = 2'b10,
    HALT_CAUSE_STEP     = 2'b11
  } halt_cause_e;

  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam int DRAIN_CNT_W = 4;

  // Drain counter is loaded with one less than the drain length so that zero marks the last cycle.
  function automatic logic [DRAIN_CNT_W-1:0] drain_load(input int cycles);
    return DRAIN_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/halt_controller_if.sv
// Request/status bundle between the pipeline/debug logic and the halt controller.
// step_req exists only when HALT_STEP_EN is defined.
interface halt_controller_if #(parameter int CNT_W = 16);

  logic             halt_req;
  logic             flush_in;
  logic             ext_halt_req;
  logic             resume_req;
`ifdef HALT_STEP_EN
  logic             step_req;
`endif
  logic             pc_stall;
  logic             fetch_kill;
  logic             halted;
  logic             resume_ack;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] halt_cycles;

  modport master (
`ifdef HALT_STEP_EN
    output step_req,
`endif
    output halt_req, flush_in, ext_halt_req, resume_req,
    input  pc_stall, fetch_kill, halted, resume_ack, halt_cause, halt_cycles
  );

  modport slave (
`ifdef HALT_STEP_EN
    input  step_req,
`endif
    input  halt_req, flush_in, ext_halt_req, resume_req,
    output pc_stall, fetch_kill, halted, resume_ack, halt_cause, halt_cycles
  );

endinterface

// File: rtl/halt_drain_counter.sv
// Small load/decrement counter timing how long older instructions need to retire after a halt.
module halt_drain_counter
  import halt_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DRAIN_CNT_W-1:0] load_val,
  input  logic                   dec,
  output logic                   zero
);

  logic [DRAIN_CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/halt_controller.sv
// Halt/resume sequencer: freezes fetch, drains the pipeline, parks in HALTED until resumed.
// Define HALT_STEP_EN to add single-step (step_req) support.
module halt_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  halt_controller_if.slave bus
);

  import halt_controller_pkg::*;

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = drain_load(DRAIN_CYCLES);

  halt_state_e      state_q;
  halt_state_e      state_d;
  halt_cause_e      cause_q;
  halt_cause_e      next_cause;
  logic [CNT_W-1:0] cycles_q;
  logic             ebreak_hit;
  logic             halt_go;
  logic             drain_zero;
  logic             drain_load_en;
  logic             drain_dec;

  // An EBREAK on a squashed path must not halt the core.
  assign ebreak_hit = bus.halt_req & ~bus.flush_in;

`ifdef HALT_STEP_EN
  logic step_q;

  assign halt_go = ebreak_hit | bus.ext_halt_req | step_q;

  // Set when leaving HALTED via a step; forces a halt after exactly one RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else if (state_q == HALT_ST_HALTED) begin
      step_q <= bus.step_req & ~bus.resume_req;
    end else if (state_q == HALT_ST_RUN) begin
      step_q <= 1'b0;
    end
  end
`else
  assign halt_go = ebreak_hit | bus.ext_halt_req;
`endif

  always_comb begin
    next_cause = ebreak_hit ? HALT_CAUSE_EBREAK : HALT_CAUSE_EXTERNAL;
`ifdef HALT_STEP_EN
    if (!ebreak_hit && step_q) begin
      next_cause = HALT_CAUSE_STEP;
    end
`endif
  end

  assign drain_load_en = (state_q == HALT_ST_RUN) && halt_go;
  assign drain_dec     = (state_q == HALT_ST_DRAIN) && !drain_zero;

  halt_drain_counter u_drain (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (drain_load_en),
    .load_val (DRAIN_LOAD),
    .dec      (drain_dec),
    .zero     (drain_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HALT_ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests other than resume/step are deliberately ignored outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT_ST_RUN: begin
        if (halt_go) state_d = HALT_ST_DRAIN;
      end
      HALT_ST_DRAIN: begin
        if (drain_zero) state_d = HALT_ST_HALTED;
      end
      HALT_ST_HALTED: begin
        if (bus.resume_req) begin
          state_d = HALT_ST_RESUME;
        end
`ifdef HALT_STEP_EN
        else if (bus.step_req) begin
          state_d = HALT_ST_RESUME;
        end
`endif
      end
      HALT_ST_RESUME: begin
        state_d = HALT_ST_RUN;
      end
      default: begin
        state_d = HALT_ST_RUN;
      end
    endcase
  end

  always_comb begin
    bus.pc_stall   = 1'b0;
    bus.fetch_kill = 1'b0;
    bus.halted     = 1'b0;
    bus.resume_ack = 1'b0;
    case (state_q)
      HALT_ST_DRAIN: begin
        bus.pc_stall   = 1'b1;
        bus.fetch_kill = 1'b1;
      end
      HALT_ST_HALTED: begin
        bus.pc_stall   = 1'b1;
        bus.fetch_kill = 1'b1;
        bus.halted     = 1'b1;
      end
      HALT_ST_RESUME: begin
        bus.resume_ack = 1'b1;
      end
      default: begin
        bus.pc_stall = 1'b0;
      end
    endcase
  end

  // Cause and halted-cycle count are captured at halt accept and held until the next halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q  <= HALT_CAUSE_NONE;
      cycles_q <= '0;
    end else if (drain_load_en) begin
      cause_q  <= next_cause;
      cycles_q <= '0;
    end else if (state_q == HALT_ST_HALTED && cycles_q != '1) begin
      cycles_q <= cycles_q + 1'b1;
    end
  end

  assign bus.halt_cause  = cause_q;
  assign bus.halt_cycles = cycles_q;

endmodule

// File: tb/tb_halt_controller.sv
// Self-checking bench for halt_controller: vector table, randomized run against a timing model,
// and directed sequences (reset mid-drain, halted-cycle count, saturation, step under HALT_STEP_EN).
module tb_halt_controller;

  localparam int DA = 3;

  logic clk;
  logic rst_n;

  int tests;
  int failures;

  halt_controller_if #(.CNT_W(16)) bus_a ();
  halt_controller_if #(.CNT_W(4))  bus_b ();

  halt_controller #(.DRAIN_CYCLES(DA), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  halt_controller #(.DRAIN_CYCLES(1), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

`ifdef HALT_STEP_EN
  logic step_drv;
  assign bus_a.step_req = step_drv;
  assign bus_b.step_req = step_drv;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        h;
    logic        f;
    logic        e;
    logic        r;
    logic [21:0] exp;
  } vec_t;

  // Reference model: halt is "in progress" from accept until resume; the core counts as parked
  // once DA edges have passed since the accept.
  bit       m_in_halt;
  int       m_k;
  bit       m_pulse;
  bit [1:0] m_cause;
  int       m_parked;

  function automatic logic [21:0] expVec(input logic stall, input logic hlt, input logic ack,
                                         input logic [1:0] cause, input logic [15:0] cyc);
    return {stall, stall, hlt, ack, cause, cyc};
  endfunction

  function automatic logic [21:0] packA();
    return {bus_a.pc_stall, bus_a.fetch_kill, bus_a.halted, bus_a.resume_ack,
            bus_a.halt_cause, bus_a.halt_cycles};
  endfunction

  function automatic logic [21:0] packB();
    return {bus_b.pc_stall, bus_b.fetch_kill, bus_b.halted, bus_b.resume_ack,
            bus_b.halt_cause, 12'd0, bus_b.halt_cycles};
  endfunction

  function automatic logic [21:0] expB(input logic stall, input logic hlt, input logic ack,
                                       input logic [1:0] cause, input logic [3:0] cyc);
    return {stall, stall, hlt, ack, cause, 12'd0, cyc};
  endfunction

  function automatic logic [21:0] modelExpect();
    bit parked;
    parked = m_in_halt && (m_k >= DA);
    return {m_in_halt, m_in_halt, parked, m_pulse, m_cause, 16'(m_parked)};
  endfunction

  function automatic vec_t row(input logic h, input logic f, input logic e, input logic r,
                               input logic stall, input logic hlt, input logic ack,
                               input logic [1:0] cause, input logic [15:0] cyc);
    return {h, f, e, r, expVec(stall, hlt, ack, cause, cyc)};
  endfunction

  task automatic modelReset();
    m_in_halt = 1'b0;
    m_k       = 0;
    m_pulse   = 1'b0;
    m_cause   = 2'd0;
    m_parked  = 0;
  endtask

  task automatic modelStep(input logic h, input logic f, input logic e, input logic r);
    bit parked;
    parked = m_in_halt && (m_k >= DA);
    if (m_pulse) begin
      m_pulse = 1'b0;
    end else if (!m_in_halt) begin
      if ((h && !f) || e) begin
        m_in_halt = 1'b1;
        m_k       = 0;
        m_cause   = (h && !f) ? 2'd1 : 2'd2;
        m_parked  = 0;
      end
    end else if (!parked) begin
      m_k = m_k + 1;
    end else begin
      if (m_parked < 65535) m_parked = m_parked + 1;
      if (r) begin
        m_in_halt = 1'b0;
        m_pulse   = 1'b1;
      end
    end
  endtask

  task automatic driveInputs(input logic h, input logic f, input logic e, input logic r);
    bus_a.halt_req     = h;
    bus_a.flush_in     = f;
    bus_a.ext_halt_req = e;
    bus_a.resume_req   = r;
    bus_b.halt_req     = h;
    bus_b.flush_in     = f;
    bus_b.ext_halt_req = e;
    bus_b.resume_req   = r;
  endtask

  task automatic applyStimulus(input logic h, input logic f, input logic e, input logic r);
    driveInputs(h, f, e, r);
    @(posedge clk);
    modelStep(h, f, e, r);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [21:0] got, input logic [21:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic doReset();
    driveInputs(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t tbl[16];

  initial begin
    tests    = 0;
    failures = 0;
`ifdef HALT_STEP_EN
    step_drv = 1'b0;
`endif
    tbl[0]  = row(1, 1, 0, 0, 0, 0, 0, 2'd0, 16'd0);
    tbl[1]  = row(1, 1, 1, 0, 1, 0, 0, 2'd2, 16'd0);
    tbl[2]  = row(0, 0, 0, 0, 1, 0, 0, 2'd2, 16'd0);
    tbl[3]  = row(0, 0, 0, 0, 1, 0, 0, 2'd2, 16'd0);
    tbl[4]  = row(0, 0, 0, 1, 1, 1, 0, 2'd2, 16'd0);
    tbl[5]  = row(1, 0, 1, 1, 0, 0, 1, 2'd2, 16'd1);
    tbl[6]  = row(0, 0, 0, 1, 0, 0, 0, 2'd2, 16'd1);
    tbl[7]  = row(0, 0, 0, 1, 0, 0, 0, 2'd2, 16'd1);
    tbl[8]  = row(1, 0, 0, 0, 1, 0, 0, 2'd1, 16'd0);
    tbl[9]  = row(0, 0, 0, 0, 1, 0, 0, 2'd1, 16'd0);
    tbl[10] = row(0, 0, 0, 0, 1, 0, 0, 2'd1, 16'd0);
    tbl[11] = row(0, 0, 0, 0, 1, 1, 0, 2'd1, 16'd0);
    tbl[12] = row(0, 0, 0, 1, 0, 0, 1, 2'd1, 16'd1);
    tbl[13] = row(0, 0, 1, 0, 0, 0, 0, 2'd1, 16'd1);
    tbl[14] = row(0, 0, 1, 0, 1, 0, 0, 2'd2, 16'd0);
    tbl[15] = row(0, 0, 0, 0, 1, 0, 0, 2'd2, 16'd0);

    // Power-on reset
    driveInputs(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_a", packA(), 22'd0);
    checkOutput("reset_b", packB(), 22'd0);
    rst_n = 1'b1;

    // Reset asserted in the middle of a drain
    applyStimulus(1, 0, 0, 0);
    checkOutput("middrain_enter", packA(), expVec(1, 0, 0, 2'd1, 16'd0));
    applyStimulus(0, 0, 0, 0);
    checkOutput("middrain_second", packA(), expVec(1, 0, 0, 2'd1, 16'd0));
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("middrain_async_clear", packA(), 22'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("after_reset_run", packA(), modelExpect());
    checkOutput("after_reset_run_const", packA(), 22'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("full_drain_0", packA(), modelExpect());
    for (int i = 0; i < DA; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("full_drain_n", packA(), modelExpect());
    end
    checkOutput("full_drain_halted", packA(), expVec(1, 1, 0, 2'd1, 16'd0));

    // Table-driven vectors from a clean reset
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].h, tbl[i].f, tbl[i].e, tbl[i].r);
      checkOutput($sformatf("table_%0d", i), packA(), tbl[i].exp);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0));
      checkOutput("random", packA(), modelExpect());
    end

    // Long halt: count on the wide instance, saturation on the narrow single-drain instance
    doReset();
    applyStimulus(0, 0, 1, 0);
    checkOutput("long_a_drain", packA(), expVec(1, 0, 0, 2'd2, 16'd0));
    checkOutput("long_b_drain", packB(), expB(1, 0, 0, 2'd2, 4'd0));
    applyStimulus(0, 0, 0, 0);
    checkOutput("b_one_drain_cycle", packB(), expB(1, 1, 0, 2'd2, 4'd0));
    repeat (2) applyStimulus(0, 0, 0, 0);
    checkOutput("long_a_halted", packA(), expVec(1, 1, 0, 2'd2, 16'd0));
    repeat (19) applyStimulus(0, 0, 0, 0);
    checkOutput("long_a_19", packA(), expVec(1, 1, 0, 2'd2, 16'd19));
    repeat (20) applyStimulus(0, 0, 0, 0);
    checkOutput("b_saturated", packB(), expB(1, 1, 0, 2'd2, 4'd15));
    checkOutput("long_a_39", packA(), modelExpect());
    doReset();
    applyStimulus(0, 0, 1, 0);
    repeat (DA) applyStimulus(0, 0, 0, 0);
    repeat (19) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("resume_a_count20", packA(), expVec(0, 0, 1, 2'd2, 16'd20));
    checkOutput("resume_b_sat", packB(), expB(0, 0, 1, 2'd2, 4'd15));
    applyStimulus(0, 0, 0, 0);
    checkOutput("resume_a_pulse_end", packA(), expVec(0, 0, 0, 2'd2, 16'd20));
    applyStimulus(1, 0, 0, 0);
    checkOutput("rehalt_a_clear", packA(), expVec(1, 0, 0, 2'd1, 16'd0));
    checkOutput("rehalt_b_clear", packB(), expB(1, 0, 0, 2'd1, 4'd0));

`ifdef HALT_STEP_EN
    // Single step: resume for one RUN cycle, then drain again with cause STEP
    doReset();
    applyStimulus(0, 0, 1, 0);
    repeat (DA) applyStimulus(0, 0, 0, 0);
    checkOutput("step_halted", packA(), expVec(1, 1, 0, 2'd2, 16'd0));
    step_drv = 1'b1;
    applyStimulus(0, 0, 0, 0);
    step_drv = 1'b0;
    checkOutput("step_resume", packA(), expVec(0, 0, 1, 2'd2, 16'd1));
    applyStimulus(0, 0, 0, 0);
    checkOutput("step_run", packA(), expVec(0, 0, 0, 2'd2, 16'd1));
    applyStimulus(0, 0, 0, 0);
    checkOutput("step_drain", packA(), expVec(1, 0, 0, 2'd3, 16'd0));
    repeat (DA) applyStimulus(0, 0, 0, 0);
    checkOutput("step_parked", packA(), expVec(1, 1, 0, 2'd3, 16'd0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
